result_buffer: RTL and testbench

Transmit-side counterpart of the instruction input path. Accepts 64-bit result words from the controller and systolic array, queues them in a circular FIFO, and presents them to the external interface through a registered valid/ready output stage. Instructions flow in through the input buffer; results flow out through this block. The producer side is throttled when the FIFO is full.

---
 rtl/result_buffer_pkg.sv | 20 ++
 rtl/result_buffer_ram.sv | 38 +++
 rtl/result_buffer.sv | 119 +++++++++++
 tb/tb_result_buffer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/result_buffer_pkg.sv
// Shared definitions for the instruction/result buffer pair: word width,
// queue geometry, and the output-stage state encoding.
package result_buffer_pkg;

  localparam int DATA_WIDTH  = 64;
  localparam int QUEUE_DEPTH = 64;
  localparam int ADDR_WIDTH  = 6;

  // Occupancy is 0..QUEUE_DEPTH inclusive, hence one extra bit.
  localparam logic [ADDR_WIDTH:0]   FULL_COUNT = QUEUE_DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = 1;

  // Output stage: EMPTY has nothing presented, HOLD presents a word.
  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } out_state_t;

endpackage

// File: rtl/result_buffer_ram.sv
// Queue storage: one synchronous write port and one registered read port.
// The read register doubles as the output-stage data register, so a word
// loaded on a pop is presented directly on the following cycle.
module result_buffer_ram
  import result_buffer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_reg;

  // Memory write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read; only the presented word is cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_reg <= '0;
    end else if (rd_en) begin
      rd_data_reg <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/result_buffer.sv
// Result transmit buffer: circular FIFO of result words feeding a
// registered valid/ready output stage. Producer is throttled by
// result_ready, which depends only on the registered occupancy.
module result_buffer
  import result_buffer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] result_in,
  input  logic                  result_valid,
  output logic                  result_ready,
  output logic [DATA_WIDTH-1:0] interface_output,
  output logic                  interface_valid,
  input  logic                  interface_ready,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  buffer_full,
  output logic                  buffer_empty,
  output logic                  overflow_err
);

  logic [ADDR_WIDTH-1:0] head_reg;
  logic [ADDR_WIDTH-1:0] tail_reg;
  logic [ADDR_WIDTH:0]   count_reg;
  logic [ADDR_WIDTH:0]   count_next;
  out_state_t            state_reg;
  logic                  valid_reg;
  logic                  overflow_reg;
  logic                  push;
  logic                  pop;
  logic                  mem_has_data;

  assign mem_has_data = (count_reg != '0);
  assign result_ready = (count_reg != FULL_COUNT);
  assign push         = result_valid && result_ready;
  // A pop loads the output stage: when it is empty, or when the held word
  // is being accepted this cycle.
  assign pop          = mem_has_data && ((state_reg == EMPTY) || interface_ready);

  result_buffer_ram u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_addr (tail_reg),
    .wr_data (result_in),
    .rd_en   (pop),
    .rd_addr (head_reg),
    .rd_data (interface_output)
  );

  // Occupancy change from this cycle's push and pop.
  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + COUNT_ONE;
    end else if (!push && pop) begin
      count_next = count_reg - COUNT_ONE;
    end
  end

  // Pointers and occupancy; pointers wrap through natural rollover.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) begin
        tail_reg <= tail_reg + PTR_ONE;
      end
      if (pop) begin
        head_reg <= head_reg + PTR_ONE;
      end
      count_reg <= count_next;
    end
  end

  // Output-stage FSM with a registered valid flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= EMPTY;
      valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (mem_has_data) begin
            state_reg <= HOLD;
            valid_reg <= 1'b1;
          end
        end
        HOLD: begin
          if (interface_ready && !mem_has_data) begin
            state_reg <= EMPTY;
            valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= EMPTY;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overflow: a word offered while the queue is full is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_reg <= 1'b0;
    end else if (result_valid && !result_ready) begin
      overflow_reg <= 1'b1;
    end
  end

  assign interface_valid = valid_reg;
  assign count           = count_reg;
  assign buffer_full     = (count_reg == FULL_COUNT);
  assign buffer_empty    = !mem_has_data && !valid_reg;
  assign overflow_err    = overflow_reg;

endmodule

// File: tb/tb_result_buffer.sv
// Directed bench for result_buffer: reset, latency, backpressure, fill and
// overflow, pointer wrap under toggling ready, simultaneous push/pop and
// asynchronous reset in the middle of a transfer.
module tb_result_buffer;
  import result_buffer_pkg::*;

  logic                  clk;
  logic                  rst;
  logic [DATA_WIDTH-1:0] result_in;
  logic                  result_valid;
  logic                  result_ready;
  logic [DATA_WIDTH-1:0] interface_output;
  logic                  interface_valid;
  logic                  interface_ready;
  logic [ADDR_WIDTH:0]   count;
  logic                  buffer_full;
  logic                  buffer_empty;
  logic                  overflow_err;

  int tests_run;
  int tests_failed;

  result_buffer dut (
    .clk              (clk),
    .rst              (rst),
    .result_in        (result_in),
    .result_valid     (result_valid),
    .result_ready     (result_ready),
    .interface_output (interface_output),
    .interface_valid  (interface_valid),
    .interface_ready  (interface_ready),
    .count            (count),
    .buffer_full      (buffer_full),
    .buffer_empty     (buffer_empty),
    .overflow_err     (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end else begin
      $display("[TB] ok %s = 0x%0h", tag, observed);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int p;
    int e;
    int cyc;
    logic push_ok;
    logic pop_ok;

    tests_run       = 0;
    tests_failed    = 0;
    rst             = 1'b1;
    result_in       = '0;
    result_valid    = 1'b0;
    interface_ready = 1'b0;

    // Reset state
    #1 rst = 1'b0;
    #1;
    check_value("rst_valid",    64'(interface_valid), 64'd0);
    check_value("rst_output",   interface_output,     64'd0);
    check_value("rst_count",    64'(count),           64'd0);
    check_value("rst_full",     64'(buffer_full),     64'd0);
    check_value("rst_empty",    64'(buffer_empty),    64'd1);
    check_value("rst_overflow", 64'(overflow_err),    64'd0);
    check_value("rst_ready",    64'(result_ready),    64'd1);
    step();
    step();
    rst = 1'b1;

    // Single push latency
    interface_ready = 1'b1;
    result_in       = 64'h0000_0000_DEAD_BEEF;
    result_valid    = 1'b1;
    step();
    result_valid = 1'b0;
    check_value("single_cnt1",   64'(count),           64'd1);
    check_value("single_val0",   64'(interface_valid), 64'd0);
    step();
    check_value("single_val1",   64'(interface_valid), 64'd1);
    check_value("single_data",   interface_output,     64'h0000_0000_DEAD_BEEF);
    check_value("single_cnt0",   64'(count),           64'd0);
    step();
    check_value("single_done",   64'(interface_valid), 64'd0);
    check_value("single_empty",  64'(buffer_empty),    64'd1);

    // Backpressure with three words
    interface_ready = 1'b0;
    result_valid    = 1'b1;
    result_in       = 64'hA;
    step();
    check_value("bp_cnt_a", 64'(count), 64'd1);
    result_in = 64'hB;
    step();
    check_value("bp_hold_a", interface_output, 64'hA);
    check_value("bp_cnt_b",  64'(count),       64'd1);
    result_in = 64'hC;
    step();
    result_valid = 1'b0;
    check_value("bp_cnt_c",  64'(count),       64'd2);
    check_value("bp_hold_a2", interface_output, 64'hA);
    step();
    check_value("bp_stable", interface_output, 64'hA);
    check_value("bp_valid",  64'(interface_valid), 64'd1);
    interface_ready = 1'b1;
    step();
    check_value("bp_out_b", interface_output, 64'hB);
    step();
    check_value("bp_out_c", interface_output, 64'hC);
    check_value("bp_cnt0",  64'(count),       64'd0);
    step();
    check_value("bp_drained", 64'(interface_valid), 64'd0);
    interface_ready = 1'b0;

    // Fill to capacity and overflow
    for (int i = 0; i < 66; i++) begin
      result_in    = 64'(32'h100 + i);
      result_valid = 1'b1;
      check_value($sformatf("fill_ready%0d", i), 64'(result_ready),
                  (i < 65) ? 64'd1 : 64'd0);
      step();
    end
    result_valid = 1'b0;
    check_value("fill_full",     64'(buffer_full),  64'd1);
    check_value("fill_count",    64'(count),        64'd64);
    check_value("fill_overflow", 64'(overflow_err), 64'd1);
    check_value("fill_head",     interface_output,  64'h100);
    interface_ready = 1'b1;
    for (int j = 1; j <= 64; j++) begin
      step();
      check_value($sformatf("drain%0d", j), interface_output, 64'(32'h100 + j));
    end
    check_value("drain_count", 64'(count), 64'd0);
    step();
    check_value("drain_done",      64'(interface_valid), 64'd0);
    check_value("overflow_sticky", 64'(overflow_err),    64'd1);

    // Wrap-around stream with ready toggling every 3 cycles
    p = 0;
    e = 0;
    cyc = 0;
    while (e < 200 && cyc < 3000) begin
      interface_ready = ((cyc / 3) % 2) == 0;
      result_valid    = (p < 200);
      result_in       = 64'(p);
      #1;
      push_ok = result_valid && result_ready;
      pop_ok  = interface_valid && interface_ready;
      if (pop_ok) begin
        check_value($sformatf("wrap%0d", e), interface_output, 64'(e));
        e++;
      end
      step();
      if (push_ok) p++;
      cyc++;
    end
    result_valid = 1'b0;
    check_value("wrap_received", 64'(e), 64'd200);
    interface_ready = 1'b1;
    step();
    check_value("wrap_empty", 64'(buffer_empty), 64'd1);

    // Simultaneous push and pop at count 5
    interface_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      result_in    = 64'(32'h500 + i);
      result_valid = 1'b1;
      step();
    end
    check_value("pp_count5", 64'(count),      64'd5);
    check_value("pp_hold",   interface_output, 64'h500);
    interface_ready = 1'b1;
    result_in       = 64'h506;
    step();
    result_valid = 1'b0;
    check_value("pp_count_same", 64'(count),      64'd5);
    check_value("pp_out1",       interface_output, 64'h501);
    for (int k = 2; k <= 6; k++) begin
      step();
      check_value($sformatf("pp_out%0d", k), interface_output, 64'(32'h500 + k));
    end
    step();
    check_value("pp_done", 64'(interface_valid), 64'd0);

    // Asynchronous reset while holding with count 10
    interface_ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      result_in    = 64'(32'h600 + i);
      result_valid = 1'b1;
      step();
    end
    result_valid = 1'b0;
    check_value("mr_count10", 64'(count),           64'd10);
    check_value("mr_holding", 64'(interface_valid), 64'd1);
    rst = 1'b0;
    #1;
    check_value("mr_valid0",    64'(interface_valid), 64'd0);
    check_value("mr_count0",    64'(count),           64'd0);
    check_value("mr_overflow0", 64'(overflow_err),    64'd0);
    check_value("mr_output0",   interface_output,     64'd0);
    check_value("mr_ready",     64'(result_ready),    64'd1);
    step();
    rst             = 1'b1;
    interface_ready = 1'b1;
    result_in       = 64'h1;
    result_valid    = 1'b1;
    step();
    result_valid = 1'b0;
    check_value("mr_push_cnt", 64'(count),           64'd1);
    check_value("mr_push_v0",  64'(interface_valid), 64'd0);
    step();
    check_value("mr_push_v1",  64'(interface_valid), 64'd1);
    check_value("mr_push_dat", interface_output,     64'h1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
